ifu_fetch: RTL and testbench
============================

// Module: ifu_fetch
// PURPOSE
//  - Fetch stage directly upstream of the 256x32 instruction memory in the 5-stage MIPS pipeline.
//  - Holds the PC and drives the word address into the IM.
//  - Computes the next PC: sequential, beq-style branch, j/jal, or jr.
//  - Captures the IM output into the IF/ID pipeline register, with stall support and delayed-branch semantics.
// PARAMETERS
//  PC_RESET  32'h0000_3000  PC value loaded on reset
//  IM_BASE   32'h0000_3000  byte address mapped to IM word 0
//  IM_AW     8              IM word-address width; IM window = 4*2^IM_AW bytes
// PORTS
//  clk           in   1      rising-edge clock
//  reset         in   1      synchronous, active-high reset
//  stall         in   1      hold PC and IF/ID (hazard unit)
//  npc_sel       in   2      00 pc+4, 01 branch, 10 j/jal, 11 jr; decided in ID
//  imm16         in   16     branch offset, from the ID-stage instruction
//  instr_index   in   26     j/jal target field, from the ID-stage instruction
//  jr_target     in   32     forwarded rs value, for jr
//  im_addr       out  IM_AW  IM word address = (pc - IM_BASE)[IM_AW+1:2]
//  im_dout       in   32     IM read data; combinational, same cycle
//  pc            out  32     current fetch PC
//  id_instr      out  32     IF/ID instruction
//  id_pc4        out  32     IF/ID PC+4 of that instruction
//  id_valid      out  1      IF/ID holds a real fetch
//  fetch_err     out  1      range error; see CONFIGURATION
// BEHAVIOUR
//  - Reset (sync, priority over all inputs): pc=PC_RESET, id_instr=0, id_pc4=0, id_valid=0, fetch_err=0.
//  - im_addr is combinational from pc; IM read latency is 0.
//    - id_instr therefore captures the instruction at pc on the same edge the PC advances.
//  - Next PC targets (branch and jump targets are relative to id_pc4, i.e. the control instruction in ID):
//    - 00: pc+4.
//    - 01: id_pc4 + {{14{imm16[15]}}, imm16, 2'b00}.
//    - 10: {id_pc4[31:28], instr_index, 2'b00}.
//    - 11: {jr_target[31:2], 2'b00}; low two bits are forced to zero.
//  - Normal edge (stall=0):
//    - pc <= next PC.
//    - id_instr <= im_dout, id_pc4 <= pc+4, id_valid <= 1.
//  - Delayed branch:
//    - When a redirect (npc_sel != 00) is accepted, the instruction being fetched that cycle (the delay slot) still enters IF/ID.
//    - No flush exists.
//  - Stall=1: pc, id_instr, id_pc4 and id_valid all hold.
//    - A redirect presented with stall=1 is ignored.
//    - ID re-presents it next cycle because IF/ID held; stall wins.
//  - Arithmetic is 32-bit modulo 2^32: pc 32'hFFFF_FFFC + 4 = 0. Branch add overflow wraps silently.
//  - im_addr truncates (pc - IM_BASE) to IM_AW word bits, so out-of-window PCs alias into the IM.
//  - Reset asserted mid-stall or mid-redirect: reset wins; the next non-reset cycle fetches PC_RESET.
//  - No state machine beyond the PC/IF-ID registers; id_valid is the only pipeline-fill state.
// CONFIGURATION
//  - Macro FETCH_RANGE_CHK_EN defined:
//    - Out of window means pc < IM_BASE or pc >= IM_BASE + 4*2^IM_AW.
//    - On an accepted edge with an out-of-window pc, id_instr <= 32'h0 (nop) instead of im_dout.
//    - fetch_err <= 1 on that edge and stays set (sticky) until reset.
//    - PC update is unaffected.
//  - Macro not defined: fetch_err is tied 0, im_dout is always captured, and addresses alias as above.
// TESTING
//  - Reset 1 cycle -> pc=0x3000, im_addr=0, id_valid=0; next edge -> id_instr=IM[0], id_pc4=0x3004, pc=0x3004.
//  - 4 sequential edges from reset -> pc=0x3010; id_instr=IM[3], id_pc4=0x3010.
//  - Branch with id_pc4=0x3008, imm16=16'hFFFE, npc_sel=01 -> pc=0x3000; delay slot IM[2] enters IF/ID.
//  - j with id_pc4=0x3010, instr_index=26'h0000C10, npc_sel=10 -> pc=0x3040; then jr with jr_target=0x3023 -> pc=0x3020.
//  - stall=1 for 3 cycles with npc_sel=01 -> pc/id_* unchanged; release stall -> redirect taken once.
//  - FETCH_RANGE_CHK_EN defined, jr to 0x3400 (IM_AW=8) -> id_instr=0, fetch_err=1, sticky until reset.
//    Macro undefined, same jr -> im_addr=0, id_instr=IM[0], fetch_err=0.

Source files
------------

// File: rtl/ifu_fetch.sv
// ifu_fetch: PC register, next-PC select and IF/ID capture for the 5-stage MIPS pipeline.
// Optional FETCH_RANGE_CHK_EN: out-of-window fetches capture a nop and set a sticky fetch_err.
module ifu_fetch #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter logic [31:0] IM_BASE  = 32'h0000_3000,
   parameter int unsigned IM_AW    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic [1:0]       npc_sel,
   input  logic [15:0]      imm16,
   input  logic [25:0]      instr_index,
   input  logic [31:0]      jr_target,
   output logic [IM_AW-1:0] im_addr,
   input  logic [31:0]      im_dout,
   output logic [31:0]      pc,
   output logic [31:0]      id_instr,
   output logic [31:0]      id_pc4,
   output logic             id_valid,
   output logic             fetch_err
);

   localparam int unsigned XLEN     = 32;
   localparam int unsigned WORD_LSB = 2;
   localparam logic [1:0]  SEL_SEQ  = 2'b00;
   localparam logic [1:0]  SEL_BR   = 2'b01;
   localparam logic [1:0]  SEL_J    = 2'b10;
   localparam logic [1:0]  SEL_JR   = 2'b11;

   logic [XLEN-1:0] pc_off;
   logic [XLEN-1:0] pc4;
   logic [XLEN-1:0] br_off;
   logic [XLEN-1:0] npc;
   logic [XLEN-1:0] fetch_word;
   logic            unused_bits;

   // IM word address: offset from the IM base, truncated so out-of-window PCs alias.
   assign pc_off  = pc - IM_BASE;
   assign im_addr = pc_off[IM_AW+WORD_LSB-1:WORD_LSB];
   assign pc4     = pc + XLEN'(4);
   assign br_off  = {{14{imm16[15]}}, imm16, 2'b00};

   // Branch and jump targets are relative to the control instruction sitting in ID.
   always_comb begin
      npc = pc4;
      unique case (npc_sel)
         SEL_SEQ: npc = pc4;
         SEL_BR:  npc = id_pc4 + br_off;
         SEL_J:   npc = {id_pc4[31:28], instr_index, 2'b00};
         SEL_JR:  npc = {jr_target[31:2], 2'b00};
         default: npc = pc4;
      endcase
   end

`ifdef FETCH_RANGE_CHK_EN
   logic in_window;

   // pc_off wraps huge when pc < IM_BASE, so one upper-bits test covers both bounds.
   assign in_window   = (pc_off[XLEN-1:IM_AW+WORD_LSB] == '0);
   assign fetch_word  = in_window ? im_dout : '0;
   assign unused_bits = ^{pc_off[WORD_LSB-1:0], jr_target[1:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_err <= 1'b0;
      end else if (!stall && !in_window) begin
         fetch_err <= 1'b1;
      end
   end
`else
   assign fetch_word  = im_dout;
   assign fetch_err   = 1'b0;
   assign unused_bits = ^{pc_off[XLEN-1:IM_AW+WORD_LSB], pc_off[WORD_LSB-1:0], jr_target[1:0]};
`endif

   // PC and IF/ID advance together; the delay-slot fetch always enters IF/ID.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc       <= PC_RESET;
         id_instr <= '0;
         id_pc4   <= '0;
         id_valid <= 1'b0;
      end else if (!stall) begin
         pc       <= npc;
         id_instr <= fetch_word;
         id_pc4   <= pc4;
         id_valid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed cases plus random traffic against a reference model.
module tb_ifu_fetch;

   localparam logic [31:0] PC_RESET = 32'h0000_3000;
   localparam logic [31:0] IM_BASE  = 32'h0000_3000;
   localparam int unsigned IM_AW    = 8;
   localparam int unsigned IM_WORDS = 256;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [1:0]  npc_sel;
   logic [15:0] imm16;
   logic [25:0] instr_index;
   logic [31:0] jr_target;
   logic [7:0]  im_addr;
   logic [31:0] im_dout;
   logic [31:0] pc;
   logic [31:0] id_instr;
   logic [31:0] id_pc4;
   logic        id_valid;
   logic        fetch_err;

   logic [31:0] im [IM_WORDS];

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid, m_err;

   ifu_fetch #(.PC_RESET(PC_RESET), .IM_BASE(IM_BASE), .IM_AW(IM_AW)) dut (
      .clk(clk), .reset(reset), .stall(stall), .npc_sel(npc_sel), .imm16(imm16),
      .instr_index(instr_index), .jr_target(jr_target), .im_addr(im_addr), .im_dout(im_dout),
      .pc(pc), .id_instr(id_instr), .id_pc4(id_pc4), .id_valid(id_valid), .fetch_err(fetch_err)
   );

   assign im_dout = im[im_addr];

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int unsigned im_index(input logic [31:0] a);
      logic [31:0] off;
      off = a - IM_BASE;
      return (off / 4) % IM_WORDS;
   endfunction

   function automatic bit out_of_window(input logic [31:0] a);
      longint la;
      la = longint'(a);
      return (la < longint'(IM_BASE)) || (la >= longint'(IM_BASE) + 4 * IM_WORDS);
   endfunction

   function automatic logic [31:0] target(input logic [1:0] sel, input logic [15:0] imm,
                                          input logic [25:0] idx, input logic [31:0] jr);
      int off;
      off = int'($signed(imm));
      case (sel)
         2'd0:    return m_pc + 32'd4;
         2'd1:    return m_pc4 + 32'(off * 4);
         2'd2:    return (m_pc4 & 32'hF000_0000) + 32'(idx) * 32'd4;
         default: return jr - (jr % 32'd4);
      endcase
   endfunction

   // One clock: drive inputs, advance the model, then compare every output.
   task automatic step(input logic r, input logic s, input logic [1:0] sel, input logic [15:0] imm,
                       input logic [25:0] idx, input logic [31:0] jr);
      logic [31:0] nxt;
      bit          oow;
      reset = r; stall = s; npc_sel = sel; imm16 = imm; instr_index = idx; jr_target = jr;
      nxt = target(sel, imm, idx, jr);
      oow = out_of_window(m_pc);
      if (r) begin
         m_pc = PC_RESET; m_instr = 0; m_pc4 = 0; m_valid = 0; m_err = 0;
      end else if (!s) begin
`ifdef FETCH_RANGE_CHK_EN
         m_instr = oow ? 32'h0 : im[im_index(m_pc)];
         m_err   = m_err | oow;
`else
         m_instr = im[im_index(m_pc)];
`endif
         m_pc4   = m_pc + 32'd4;
         m_valid = 1'b1;
         m_pc    = nxt;
      end
      @(posedge clk);
      #1;
      chk("pc", pc, m_pc);
      chk("im_addr", 32'(im_addr), 32'(im_index(m_pc)));
      chk("id_instr", id_instr, m_instr);
      chk("id_pc4", id_pc4, m_pc4);
      chk("id_valid", 32'(id_valid), 32'(m_valid));
      chk("fetch_err", 32'(fetch_err), 32'(m_err));
   endtask

   task automatic seq(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 16'h0, 26'h0, 32'h0);
   endtask

   task automatic rst();
      step(1'b1, 1'b0, 2'b00, 16'h0, 26'h0, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < IM_WORDS; i++) im[i] = $urandom;
      m_pc = 'x; m_instr = 'x; m_pc4 = 'x; m_valid = 1'bx; m_err = 1'bx;

      // Reset and sequential fetch
      rst();
      chk("rst_pc", pc, 32'h3000);
      chk("rst_addr", 32'(im_addr), 32'h0);
      chk("rst_valid", 32'(id_valid), 32'h0);
      seq(1);
      chk("seq1_instr", id_instr, im[0]);
      chk("seq1_pc4", id_pc4, 32'h3004);
      chk("seq1_pc", pc, 32'h3004);
      seq(3);
      chk("seq4_pc", pc, 32'h3010);
      chk("seq4_instr", id_instr, im[3]);
      chk("seq4_pc4", id_pc4, 32'h3010);

      // Backward branch with delay slot
      rst(); seq(2);
      step(1'b0, 1'b0, 2'b01, 16'hFFFE, 26'h0, 32'h0);
      chk("br_pc", pc, 32'h3000);
      chk("br_slot", id_instr, im[2]);

      // j then jr with unaligned target
      rst(); seq(4);
      step(1'b0, 1'b0, 2'b10, 16'h0, 26'h0000C10, 32'h0);
      chk("j_pc", pc, 32'h3040);
      step(1'b0, 1'b0, 2'b11, 16'h0, 26'h0, 32'h3023);
      chk("jr_pc", pc, 32'h3020);

      // Stall holds everything and suppresses the redirect
      rst(); seq(2);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 2'b01, 16'hFFFE, 26'h0, 32'h0);
         chk("stall_pc", pc, 32'h3008);
         chk("stall_pc4", id_pc4, 32'h3008);
      end
      step(1'b0, 1'b0, 2'b01, 16'hFFFE, 26'h0, 32'h0);
      chk("unstall_pc", pc, 32'h3000);
      chk("unstall_slot", id_instr, im[2]);
      seq(1);
      chk("after_pc", pc, 32'h3004);

      // Reset wins over stall and redirect
      step(1'b1, 1'b1, 2'b11, 16'h0, 26'h0, 32'h0000_4000);
      chk("rststall_pc", pc, PC_RESET);
      seq(1);
      chk("rststall_instr", id_instr, im[0]);

      // PC wrap at the top of the address space
      step(1'b0, 1'b0, 2'b11, 16'h0, 26'h0, 32'hFFFF_FFFC);
      seq(1);
      chk("wrap_pc", pc, 32'h0);
      chk("wrap_pc4", id_pc4, 32'h0);

      // Out-of-window fetch and sticky error
      rst();
      step(1'b0, 1'b0, 2'b11, 16'h0, 26'h0, 32'h0000_3400);
      chk("oow_addr", 32'(im_addr), 32'h0);
      seq(1);
`ifdef FETCH_RANGE_CHK_EN
      chk("oow_instr", id_instr, 32'h0);
      chk("oow_err", 32'(fetch_err), 32'h1);
`else
      chk("oow_instr", id_instr, im[0]);
      chk("oow_err", 32'(fetch_err), 32'h0);
`endif
      step(1'b0, 1'b0, 2'b11, 16'h0, 26'h0, 32'h0000_3000);
      seq(2);
`ifdef FETCH_RANGE_CHK_EN
      chk("sticky_err", 32'(fetch_err), 32'h1);
`else
      chk("sticky_err", 32'(fetch_err), 32'h0);
`endif
      rst();
      chk("err_clr", 32'(fetch_err), 32'h0);

      // Random traffic against the model
      for (int i = 0; i < 800; i++) begin
         logic        r, s;
         logic [1:0]  sel;
         logic [15:0] imm;
         logic [25:0] idx;
         logic [31:0] jr;
         r   = ($urandom_range(0, 63) == 0);
         s   = ($urandom_range(0, 4) == 0);
         sel = 2'($urandom_range(0, 3));
         imm = 16'($signed($urandom_range(0, 32)) - 16);
         idx = ($urandom_range(0, 7) == 0) ? 26'($urandom)
                                           : 26'((IM_BASE >> 2) + $urandom_range(0, IM_WORDS - 1));
         jr  = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                           : IM_BASE + 32'($urandom_range(0, 4 * IM_WORDS - 1));
         step(r, s, sel, imm, idx, jr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
